// File: rtl/rr_arb_sel_pkg.sv
// Shared types and helpers for the round-robin arbiter slice (rr_arb_sel).
// arbstate_t is used only when the packet-lock feature (ARB_LOCK_EN) is built.
package arb_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arbstate_t;

    // Widest one-hot vector onehot2idx accepts; callers zero-extend into it.
    localparam int unsigned OH_MAX_W = 32;

    // Index of the set bit of a one-hot vector; returns 0 for an all-zero vector.
    function automatic int unsigned onehot2idx(input logic [OH_MAX_W-1:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int unsigned i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_sel_if.sv
// Requester/consumer bundle of rr_arb_sel. The slave modport is the arbiter side.
// ReqLast exists only when ARB_LOCK_EN is defined.
interface rr_arb_sel_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]       ReqValid;
    logic [N*WIDTH-1:0] ReqData;
    logic [N-1:0]       ReqReady;
`ifdef ARB_LOCK_EN
    logic [N-1:0]       ReqLast;
`endif
    logic               OutValid;
    logic               OutReady;
    logic [WIDTH-1:0]   OutData;
    logic [IW-1:0]      OutSrc;
    logic [N-1:0]       OutGrant;

    modport slave (
        input  ReqValid,
        input  ReqData,
`ifdef ARB_LOCK_EN
        input  ReqLast,
`endif
        input  OutReady,
        output ReqReady,
        output OutValid,
        output OutData,
        output OutSrc,
        output OutGrant
    );

    modport master (
        output ReqValid,
        output ReqData,
`ifdef ARB_LOCK_EN
        output ReqLast,
`endif
        output OutReady,
        input  ReqReady,
        input  OutValid,
        input  OutData,
        input  OutSrc,
        input  OutGrant
    );

endinterface

// File: rtl/rr_prio_enc.sv
// Rotating-priority encoder: one-hot grant to the first set request bit found
// starting at Ptr and wrapping around. Purely combinational.
module rr_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  Req,
    input  logic [IW-1:0] Ptr,
    output logic [N-1:0]  Grant
);

    logic [IW-1:0] idx_s;
    logic          found_s;

    // Walk the requesters in priority order from Ptr, granting the first valid one.
    always_comb begin
        Grant   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s = IW'((int'(Ptr) + k) % N);
            if (!found_s && Req[idx_s]) begin
                Grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rr_arb_sel.sv
// rr_arb_sel: N-way round-robin arbiter with a registered output stage.
// Optional packet lock: define ARB_LOCK_EN to add ReqLast and hold the grant
// on one requester until its last beat is accepted.
module rr_arb_sel
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    rr_arb_sel_if.slave  bus
);

    localparam int IW = $clog2(N);

    logic                out_valid_r;
    logic [WIDTH-1:0]    out_data_r;
    logic [IW-1:0]       out_src_r;
    logic [N-1:0]        out_grant_r;
    logic [IW-1:0]       ptr_r;

    logic                load_en_s;
    logic [N-1:0]        enc_grant_s;
    logic [N-1:0]        grant_s;
    logic [OH_MAX_W-1:0] grant_ext_s;
    logic [N-1:0]        req_ready_s;
    logic                accept_s;
    logic [IW-1:0]       g_idx_s;
    logic [IW-1:0]       ptr_nxt_s;
    logic                ptr_upd_s;

    rr_prio_enc #(.N(N), .IW(IW)) u_enc (
        .Req   (bus.ReqValid),
        .Ptr   (ptr_r),
        .Grant (enc_grant_s)
    );

    // Output register can take a beat when empty or being drained this cycle.
    assign load_en_s = ~out_valid_r | bus.OutReady;

`ifdef ARB_LOCK_EN
    arbstate_t   state_r;
    arbstate_t   state_nxt_s;
    logic [N-1:0] lock_oh_r;

    // While locked only the owning requester is eligible; otherwise rotate.
    always_comb begin
        if (state_r == LOCKED) begin
            grant_s = bus.ReqValid & lock_oh_r;
        end else begin
            grant_s = enc_grant_s;
        end
    end

    // Lock on a non-last accepted beat, unlock when the owner's last beat goes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            UNLOCKED: begin
                if (accept_s && !bus.ReqLast[g_idx_s]) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (accept_s && bus.ReqLast[g_idx_s]) begin
                    state_nxt_s = UNLOCKED;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = UNLOCKED;
        endcase
    end

    // Lock state register and the owner captured on every accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= UNLOCKED;
            lock_oh_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                lock_oh_r <= grant_s;
            end
        end
    end

    // Priority only moves at packet boundaries.
    assign ptr_upd_s = accept_s & bus.ReqLast[g_idx_s];
`else
    // Every beat is arbitrated independently.
    always_comb begin
        grant_s = enc_grant_s;
    end

    assign ptr_upd_s = accept_s;
`endif

    // Ready only to the winner and only when the output stage can load.
    always_comb begin
        if (load_en_s) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Winner index and the pointer value just past it.
    always_comb begin
        grant_ext_s        = '0;
        grant_ext_s[N-1:0] = grant_s;
        g_idx_s            = IW'(onehot2idx(grant_ext_s));
        if (g_idx_s == IW'(N - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = g_idx_s + IW'(1);
        end
    end

    assign accept_s = |req_ready_s;

    // Output stage: load on accept, empty on a drain with no new beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
            out_grant_r <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= bus.ReqData[g_idx_s*WIDTH +: WIDTH];
            out_src_r   <= g_idx_s;
            out_grant_r <= grant_s;
        end else if (out_valid_r && bus.OutReady) begin
            out_valid_r <= 1'b0;
            out_grant_r <= '0;
        end
    end

    // Round-robin pointer advances only on accepted beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (ptr_upd_s) begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign bus.ReqReady = req_ready_s;
    assign bus.OutValid = out_valid_r;
    assign bus.OutData  = out_data_r;
    assign bus.OutSrc   = out_src_r;
    assign bus.OutGrant = out_grant_r;

endmodule
